// File: rtl/mips_mdu_if.sv
// Bus between the execute stage and the multiply/divide unit.
// Groups the issue request, flush, status pulses and HI/LO read-back.
interface mips_mdu_if #(
  parameter int WIDTH = 32
);
  logic             mdu_start;
  logic [2:0]       mdu_opcode;
  logic [WIDTH-1:0] mdu_op_x;
  logic [WIDTH-1:0] mdu_op_y;
  logic             mdu_flush;
  logic             mdu_busy;
  logic             mdu_done;
  logic             mdu_div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mdu_start, mdu_opcode, mdu_op_x, mdu_op_y, mdu_flush,
    input  mdu_busy, mdu_done, mdu_div_by_zero, hi, lo
  );

  modport slave (
    input  mdu_start, mdu_opcode, mdu_op_x, mdu_op_y, mdu_flush,
    output mdu_busy, mdu_done, mdu_div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle on operand magnitudes, followed by one sign-fixup cycle.
// Optional feature macro: MDU_FAST_MUL_EN selects a single-cycle multiplier
// for MULT/MULTU; divides remain iterative either way.
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  mips_mdu_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, ITER, FIXUP, DIVZ, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic             is_div, is_signed, sign_x, sign_y, dz_flag;
  logic [WIDTH-1:0] a_reg, acc, q;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             busy, accept, op_mul, op_div, op_signed, y_zero;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy      = (state == ITER) || (state == FIXUP) || (state == DIVZ);
  assign accept    = bus.mdu_start && !busy && !bus.mdu_flush;
  assign op_mul    = (bus.mdu_opcode == 3'd0) || (bus.mdu_opcode == 3'd1);
  assign op_div    = (bus.mdu_opcode == 3'd2) || (bus.mdu_opcode == 3'd3);
  assign op_signed = !bus.mdu_opcode[0];
  assign y_zero    = (bus.mdu_op_y == '0);

  assign bus.mdu_busy        = busy;
  assign bus.mdu_done        = (state == DONE);
  assign bus.mdu_div_by_zero = (state == DONE) && dz_flag;
  assign bus.hi              = hi_reg;
  assign bus.lo              = lo_reg;

  // One iteration step for each algorithm, plus the sign-corrected results.
  always_comb begin
    mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, a_reg} : '0);
    div_shift = {acc, q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, a_reg};
    prod_mag  = {acc, q};
    prod_fix  = (is_signed && (sign_x ^ sign_y)) ? -prod_mag : prod_mag;
    quo_fix   = (is_signed && (sign_x ^ sign_y)) ? -q : q;
    rem_fix   = (is_signed && sign_x) ? -acc : acc;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: a start is taken from IDLE or DONE; flush always wins.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept && op_mul) begin
`ifdef MDU_FAST_MUL_EN
          state_next = DONE;
`else
          state_next = ITER;
`endif
        end else if (accept && op_div) begin
          state_next = y_zero ? DIVZ : ITER;
        end
      end
      ITER:    if (count == CW'(WIDTH)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DIVZ:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (bus.mdu_flush) state_next = IDLE;
  end

  // Datapath: operand capture, magnitude setup, iteration, and HI/LO writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      acc       <= '0;
      q         <= '0;
      a_reg     <= '0;
      count     <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_x    <= 1'b0;
      sign_y    <= 1'b0;
      dz_flag   <= 1'b0;
    end else if (accept) begin
      dz_flag <= op_div && y_zero;
      if (bus.mdu_opcode == 3'd4) hi_reg <= bus.mdu_op_x;
      if (bus.mdu_opcode == 3'd5) lo_reg <= bus.mdu_op_x;
`ifdef MDU_FAST_MUL_EN
      if (op_mul) begin
        {hi_reg, lo_reg} <=
          {{WIDTH{op_signed && bus.mdu_op_x[WIDTH-1]}}, bus.mdu_op_x} *
          {{WIDTH{op_signed && bus.mdu_op_y[WIDTH-1]}}, bus.mdu_op_y};
      end
`endif
      is_div    <= op_div;
      is_signed <= op_signed;
      q         <= bus.mdu_op_x;
      a_reg     <= bus.mdu_op_y;
      acc       <= '0;
      count     <= '0;
    end else if (state == ITER) begin
      count <= count + 1'b1;
      if (count == '0) begin
        sign_x <= q[WIDTH-1];
        sign_y <= a_reg[WIDTH-1];
        if (is_signed && q[WIDTH-1])     q     <= -q;
        if (is_signed && a_reg[WIDTH-1]) a_reg <= -a_reg;
      end else if (is_div) begin
        if (!div_diff[WIDTH]) begin
          acc <= div_diff[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= div_shift[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc, q} <= {mul_sum, q[WIDTH-1:1]};
      end
    end else if (state == FIXUP && !bus.mdu_flush) begin
      if (is_div) begin
        lo_reg <= quo_fix;
        hi_reg <= rem_fix;
      end else begin
        {hi_reg, lo_reg} <= prod_fix;
      end
    end
  end
endmodule

// File: tb/tb_mips_mdu.sv
// Directed self-checking bench for mips_mdu (WIDTH=32).
// Expected latencies follow MDU_FAST_MUL_EN when that macro is defined.
module tb_mips_mdu;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mips_mdu_if #(.WIDTH(32)) bus();

  mips_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns #1 after the acceptance edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.mdu_start  = 1'b1;
    bus.mdu_opcode = op;
    bus.mdu_op_x   = x;
    bus.mdu_op_y   = y;
    @(posedge clk);
    #1;
    bus.mdu_start  = 1'b0;
  endtask

  // Wait a bounded number of edges for done; report edges and busy samples seen.
  task automatic wait_done(input int max_edges, output int edges, output int busy_cnt, output logic seen);
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.mdu_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.mdu_busy === 1'b1) busy_cnt++;
    end
  endtask

  int   edges;
  int   busy_cnt;
  int   done_cnt;
  logic seen;

  // Directed sequence.
  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.mdu_start  = 1'b0;
    bus.mdu_opcode = 3'd0;
    bus.mdu_op_x   = '0;
    bus.mdu_op_y   = '0;
    bus.mdu_flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_hi", bus.hi, 0);
    check_output("reset_lo", bus.lo, 0);
    check_output("reset_busy", bus.mdu_busy, 0);
    check_output("reset_done", bus.mdu_done, 0);
    check_output("reset_dz", bus.mdu_div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULTU all-ones squared
    apply_stimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(60, edges, busy_cnt, seen);
    check_output("multu_done_seen", seen, 1);
`ifdef MDU_FAST_MUL_EN
    check_output("multu_latency", edges, 1);
    check_output("multu_busy_cycles", busy_cnt, 0);
`else
    check_output("multu_latency", edges, 34);
    check_output("multu_busy_cycles", busy_cnt, 33);
`endif
    check_output("multu_hi", bus.hi, 32'hFFFFFFFE);
    check_output("multu_lo", bus.lo, 32'h00000001);
    check_output("multu_dz", bus.mdu_div_by_zero, 0);
    @(posedge clk);
    #1;
    check_output("multu_done_pulse", bus.mdu_done, 0);

    // MULT -3 * 7
    apply_stimulus(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(60, edges, busy_cnt, seen);
    check_output("mult_done_seen", seen, 1);
`ifdef MDU_FAST_MUL_EN
    check_output("mult_latency", edges, 1);
`else
    check_output("mult_latency", edges, 34);
`endif
    check_output("mult_hi", bus.hi, 32'hFFFFFFFF);
    check_output("mult_lo", bus.lo, 32'hFFFFFFEB);

    // DIV -7 / 2
    apply_stimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(60, edges, busy_cnt, seen);
    check_output("div_latency", edges, 34);
    check_output("div_lo", bus.lo, 32'hFFFFFFFD);
    check_output("div_hi", bus.hi, 32'hFFFFFFFF);

    // DIVU 7 / 2
    apply_stimulus(3'd3, 32'd7, 32'd2);
    wait_done(60, edges, busy_cnt, seen);
    check_output("divu_done_seen", seen, 1);
    check_output("divu_lo", bus.lo, 32'd3);
    check_output("divu_hi", bus.hi, 32'd1);

    // DIV signed overflow
    apply_stimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(60, edges, busy_cnt, seen);
    check_output("ovf_done_seen", seen, 1);
    check_output("ovf_lo", bus.lo, 32'h80000000);
    check_output("ovf_hi", bus.hi, 32'h0);
    check_output("ovf_dz", bus.mdu_div_by_zero, 0);

    // MTHI / MTLO, then an ignored opcode
    apply_stimulus(3'd4, 32'h1234, 32'h0);
    check_output("mthi_hi", bus.hi, 32'h1234);
    check_output("mthi_busy", bus.mdu_busy, 0);
    check_output("mthi_done", bus.mdu_done, 0);
    apply_stimulus(3'd5, 32'h5678, 32'h0);
    check_output("mtlo_lo", bus.lo, 32'h5678);
    apply_stimulus(3'd6, 32'hAAAA, 32'hBBBB);
    check_output("op6_hi", bus.hi, 32'h1234);
    check_output("op6_lo", bus.lo, 32'h5678);
    check_output("op6_busy", bus.mdu_busy, 0);

    // DIVU 9 / 0
    apply_stimulus(3'd3, 32'd9, 32'd0);
    check_output("dz_busy", bus.mdu_busy, 1);
    wait_done(10, edges, busy_cnt, seen);
    check_output("dz_done_seen", seen, 1);
    check_output("dz_latency", edges + 1, 2);
    check_output("dz_flag", bus.mdu_div_by_zero, 1);
    check_output("dz_hi", bus.hi, 32'h1234);
    check_output("dz_lo", bus.lo, 32'h5678);
    @(posedge clk);
    #1;
    check_output("dz_flag_pulse", bus.mdu_div_by_zero, 0);

    // Iterative op, ignored start while busy, then flush
`ifdef MDU_FAST_MUL_EN
    apply_stimulus(3'd2, 32'd25, 32'd5);
`else
    apply_stimulus(3'd0, 32'd5, 32'd5);
`endif
    repeat (2) @(posedge clk);
    #1;
    bus.mdu_start  = 1'b1;
    bus.mdu_opcode = 3'd4;
    bus.mdu_op_x   = 32'hDEAD;
    @(posedge clk);
    #1;
    bus.mdu_start = 1'b0;
    check_output("busy_start_ignored", bus.hi, 32'h1234);
    repeat (6) @(posedge clk);
    #1;
    bus.mdu_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.mdu_flush = 1'b0;
    check_output("flush_busy", bus.mdu_busy, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.mdu_done === 1'b1) done_cnt++;
    end
    check_output("flush_no_done", done_cnt, 0);
    check_output("flush_hi", bus.hi, 32'h1234);
    check_output("flush_lo", bus.lo, 32'h5678);

    // Flush and start together: start dropped
    @(negedge clk);
    bus.mdu_flush = 1'b1;
    apply_stimulus(3'd5, 32'hBEEF, 32'h0);
    bus.mdu_flush = 1'b0;
    check_output("flush_start_lo", bus.lo, 32'h5678);

    // Reset in the middle of a divide
    apply_stimulus(3'd3, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("midrst_hi", bus.hi, 0);
    check_output("midrst_lo", bus.lo, 0);
    check_output("midrst_busy", bus.mdu_busy, 0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
